agg_act_resp: RTL

//  Activation responder for the aggregator. Accepts aggregated words from agg (agg_out / agg_out2act),

---
 rtl/agg_act_resp_if.sv | 27 ++
 rtl/agg_act_resp.sv | 121 ++++++++++++
 2 files changed

// File: rtl/agg_act_resp_if.sv
// Handshake bundle between agg, the activation responder and the downstream stage.
// The master side is the aggregator/downstream; the slave side is the responder.
interface agg_act_resp_if #(
    parameter int n  = 12,
    parameter int CW = 8
);
    logic          act_req;
    logic [n-1:0]  act_in;
    logic [1:0]    act_mode;
    logic          act_rdy;
    logic [n-1:0]  act_out;
    logic          act_out_valid;
    logic          act_out_ready;
    logic          act_done;
    logic          act_err;
    logic [CW-1:0] done_cnt;

    modport master (
        output act_req, act_in, act_mode, act_out_ready,
        input  act_rdy, act_out, act_out_valid, act_done, act_err, done_cnt
    );

    modport slave (
        input  act_req, act_in, act_mode, act_out_ready,
        output act_rdy, act_out, act_out_valid, act_done, act_err, done_cnt
    );
endinterface

// File: rtl/agg_act_resp.sv
// Activation responder: input FIFO, a holding stage (s1) and a registered output stage
// that applies pass / ReLU / leaky ReLU / clamped ReLU per word.
module agg_act_resp #(
    parameter int n          = 12,
    parameter int DEPTH      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP      = 255,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    agg_act_resp_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QW = PW + 1;
    localparam logic [QW-1:0] DEPTH_C = QW'(DEPTH);

    logic [n+1:0]    mem_word [DEPTH];
    logic [DEPTH-1:0] wr_en;

    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [QW-1:0]   count_reg;
    logic            s1_valid_reg;
    logic [n-1:0]    s1_data_reg;
    logic [1:0]      s1_mode_reg;
    logic            out_valid_reg;
    logic [n-1:0]    out_data_reg;
    logic            done_reg;
    logic            err_reg;
    logic [CW-1:0]   done_cnt_reg;

    logic act_rdy, push, pop, out_fire, s2_load, s1_adv;

    function automatic logic [n-1:0] activate(input logic [n-1:0] x, input logic [1:0] mode);
        logic signed [n-1:0] xs;
        logic signed [n-1:0] clamp_s;
        logic [n-1:0]        y;
        xs      = $signed(x);
        clamp_s = n'(CLAMP);
        y       = x;
        case (mode)
            2'b01: if (xs[n-1]) y = '0;
            2'b10: if (xs[n-1]) y = xs >>> LEAK_SHIFT;
            2'b11: begin
                if (xs[n-1])          y = '0;
                else if (xs > clamp_s) y = clamp_s;
            end
            default: y = x;
        endcase
        return y;
    endfunction

    // Ready depends only on occupancy so upstream never sees a combinational path from downstream.
    assign act_rdy  = (count_reg < DEPTH_C);
    assign push     = bus.act_req & act_rdy;
    assign out_fire = out_valid_reg & bus.act_out_ready;
    assign s2_load  = ~out_valid_reg | out_fire;
    assign s1_adv   = s1_valid_reg & s2_load;
    assign pop      = (count_reg != '0) & (~s1_valid_reg | s1_adv);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
            assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Storage carries no reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) mem_word[i] <= {bus.act_mode, bus.act_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            s1_valid_reg  <= 1'b0;
            s1_data_reg   <= '0;
            s1_mode_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            done_cnt_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + QW'(1);
                2'b01:   count_reg <= count_reg - QW'(1);
                default: count_reg <= count_reg;
            endcase

            if (pop) begin
                s1_valid_reg <= 1'b1;
                s1_data_reg  <= mem_word[rd_ptr_reg][n-1:0];
                s1_mode_reg  <= mem_word[rd_ptr_reg][n+1:n];
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_load) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) out_data_reg <= activate(s1_data_reg, s1_mode_reg);
            end

            done_reg <= out_fire;
            if (out_fire) done_cnt_reg <= done_cnt_reg + CW'(1);
            if (bus.act_req && !act_rdy) err_reg <= 1'b1;
        end
    end

    assign bus.act_rdy       = act_rdy;
    assign bus.act_out       = out_data_reg;
    assign bus.act_out_valid = out_valid_reg;
    assign bus.act_done      = done_reg;
    assign bus.act_err       = err_reg;
    assign bus.done_cnt      = done_cnt_reg;
endmodule
